mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters: instruction fetch (IF, read-only) and the MEM-stage data access (D, read/write).
- Sits between the IF/MEM pipeline stages and the backing memory.
- Serialises accesses with a request/ack handshake and a variable-latency memory valid strobe.
- Produces stall signals that the pipeline uses to freeze PC, IF/ID and EX/MEM while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF (read-only) and D (read/write) requesters.
// Define ARB_PERF_CNT_EN to add grant and conflict performance counters.
module mem_port_arbiter #(
  parameter int N = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ack,
  output logic         mem_en,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_valid,
  output logic         stall_if,
  output logic         stall_mem,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]  perf_grants_if,
  output logic [31:0]  perf_grants_d,
  output logic [31:0]  perf_conflicts,
`endif
  output logic         err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic own_d;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic grant_d;
  logic done;
  // IF only wins a conflict once D has taken MAX_STREAK grants in a row while IF waited
  assign grant_d = d_req & ~(if_req & (streak == 4'(MAX_STREAK)));
  assign done = mem_valid | (tcnt == 8'(TIMEOUT - 1));
  assign stall_if = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      own_d <= 1'b0;
      streak <= '0;
      tcnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req | d_req) begin
          state <= ISSUE;
          own_d <= grant_d;
          mem_en <= 1'b1;
          mem_we <= grant_d & d_we;
          mem_addr <= grant_d ? d_addr : if_addr;
          mem_wdata <= d_wdata;
          streak <= (grant_d & if_req) ? streak + 4'(streak != 4'(MAX_STREAK)) : '0;
        end
        ISSUE: begin
          state <= WAIT;
          mem_en <= 1'b0;
          tcnt <= '0;
        end
        WAIT: if (done) begin
          state <= RESP;
          if_ack <= ~own_d;
          d_ack <= own_d;
          err <= ~mem_valid;
          if (!own_d) if_rdata <= mem_valid ? mem_rdata : '0;
          else if (!mem_we) d_rdata <= mem_valid ? mem_rdata : '0;
        end else tcnt <= tcnt + 8'd1;
        RESP: begin
          state <= IDLE;
          if_ack <= 1'b0;
          d_ack <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_grants_if <= '0;
      perf_grants_d <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE) begin
      perf_grants_if <= perf_grants_if + 32'(if_req & ~grant_d);
      perf_grants_d <= perf_grants_d + 32'(grant_d);
      perf_conflicts <= perf_conflicts + 32'(if_req & d_req);
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_valid = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem, err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_grants_if, perf_grants_d, perf_conflicts;
`endif
  always #5 clk = ~clk;
  mem_port_arbiter #(.N(32), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_PERF_CNT_EN
    .perf_grants_if(perf_grants_if), .perf_grants_d(perf_grants_d), .perf_conflicts(perf_conflicts),
`endif
    .err(err)
  );
  int n_chk = 0, n_fail = 0, cyc = 0;
  int issue_c, ack_c, valid_c, free_at, streak, stray_c = -1, f_lat = -2;
  bit busy, own_d, acc_we, tmo, spur, if_act, d_act, saw_if, saw_d, f_data_en;
  logic [31:0] exp_addr, exp_wdata, ret_data, exp_if_rd, exp_d_rd, f_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit want(input int mode);
    return mode == 1 || (mode == 0 && $urandom_range(0, 2) != 0);
  endfunction
  // One cycle: drive inputs #1 after posedge, predict from the access timeline, check at negedge
  task automatic step(input int mode);
    bit gd, e_en, e_ia, e_da, e_err, fin;
    int d;
    if (saw_if) if_act = 0;
    if (saw_d) d_act = 0;
    if (!if_act && want(mode)) begin if_act = 1; if_addr = $urandom; end
    if (!d_act && want(mode)) begin
      d_act = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end
    if_req = if_act;
    d_req = d_act;
    if (!busy && cyc >= free_at && (if_req || d_req)) begin
      gd = d_req && !(if_req && streak == MAX_STREAK);
      streak = (gd && if_req) ? (streak < MAX_STREAK ? streak + 1 : streak) : 0;
      busy = 1; own_d = gd; acc_we = gd && d_we;
      exp_addr = gd ? d_addr : if_addr;
      exp_wdata = d_wdata;
      issue_c = cyc + 1;
      ret_data = f_data_en ? f_data : $urandom;
      spur = $urandom_range(0, 3) == 0;
      d = f_lat;
      if (d == -2)
        case ($urandom_range(0, 9))
          0: d = -1;
          1: d = TIMEOUT;
          2: d = TIMEOUT + 1;
          default: d = $urandom_range(1, 4);
        endcase
      tmo = d < 0 || d > TIMEOUT;
      valid_c = d < 0 ? -1 : issue_c + d;
      ack_c = tmo ? issue_c + 1 + TIMEOUT : valid_c + 1;
    end
    mem_valid = (busy && (cyc == valid_c || (spur && cyc == issue_c))) || cyc == stray_c;
    mem_rdata = (busy && cyc == valid_c) ? ret_data : $urandom;
    @(negedge clk);
    fin = busy && cyc == ack_c;
    e_en = busy && cyc == issue_c;
    e_ia = fin && !own_d;
    e_da = fin && own_d;
    e_err = fin && tmo;
    if (e_ia) exp_if_rd = tmo ? 32'h0 : ret_data;
    if (e_da && !acc_we) exp_d_rd = tmo ? 32'h0 : ret_data;
    check("mem_en", mem_en, e_en);
    check("if_ack", if_ack, e_ia);
    check("d_ack", d_ack, e_da);
    check("err", err, e_err);
    check("if_rdata", if_rdata, exp_if_rd);
    check("d_rdata", d_rdata, exp_d_rd);
    check("stall_if", stall_if, if_req & ~e_ia);
    check("stall_mem", stall_mem, d_req & ~e_da);
    if (busy && cyc >= issue_c) check("mem_addr", mem_addr, exp_addr);
    if (e_en) check("mem_we", mem_we, acc_we);
    if (busy && acc_we && cyc >= issue_c) check("mem_wdata", mem_wdata, exp_wdata);
    saw_if = e_ia;
    saw_d = e_da;
    if (fin) begin busy = 0; free_at = cyc + 1; end
    @(posedge clk); #1; cyc++;
  endtask
  task automatic apply_reset(input bit hold_if, input int n);
    rst_n = 0; if_act = hold_if; d_act = 0; if_req = hold_if; d_req = 0; mem_valid = 0;
    busy = 0; streak = 0; exp_if_rd = '0; exp_d_rd = '0; saw_if = 0; saw_d = 0;
    repeat (n) begin
      @(negedge clk);
      check("rst_mem_en", mem_en, 0);
      check("rst_if_ack", if_ack, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_err", err, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_stall_if", stall_if, hold_if);
      @(posedge clk); #1; cyc++;
    end
    rst_n = 1;
    free_at = cyc;
  endtask
  initial begin
    @(posedge clk); #1;
    if_addr = 32'h10;
    apply_reset(1, 3);
    f_lat = 1; f_data_en = 1; f_data = 32'hDEADBEEF;
    repeat (8) step(2);
    f_data_en = 0; f_lat = -2;
    if_act = 1; if_addr = 32'h30;
    d_act = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
    repeat (25) step(2);
    f_lat = 1;
    repeat (80) step(1);
    repeat (10) step(2);
    f_lat = -1;
    d_act = 1; d_we = 0; d_addr = 32'h44;
    repeat (25) step(2);
    d_act = 1; d_we = 0; d_addr = 32'h48;
    for (int i = 0; i < 10 && !(busy && cyc >= issue_c + 2); i++) step(2);
    apply_reset(0, 2);
    stray_c = cyc + 2;
    f_lat = -2;
    repeat (5) step(2);
    if_act = 1; if_addr = 32'h84;
    repeat (30) step(2);
    repeat (3000) step(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
